// File: rtl/turn_pkg.sv
// Shared types and constants for the turn manager.
//   turn_state_t : turn phase. The encoding is visible on the phase output.
//   KEY_NONE     : keycode value meaning "no key pressed".
//   CNT_W        : width of the frame counter and of the turn timer.
//   shoot_hit()  : true when a raw keycode is a real press of the given shoot key.
package turn_pkg;

  typedef enum logic [1:0] {
    AIM       = 2'd0,
    FIRE_WAIT = 2'd1,
    FLIGHT    = 2'd2,
    SWITCH    = 2'd3
  } turn_state_t;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam int         CNT_W    = 10;

  // An idle keyboard (KEY_NONE) must never fire. This holds even when a
  // player's shoot key is configured as 0.
  function automatic logic shoot_hit(input logic [7:0] key, input logic [7:0] shoot);
    return (key != KEY_NONE) && (key == shoot);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Frame counter shared by every turn phase.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart from 0. Takes priority over enable.
//   enable     : count one step (driven by frame_tick)
//   limit      : terminal value for the current phase
//   count      : current count, saturating at all-ones
//   done       : count has reached limit. It is already true at count 0 when limit is 0.
module frame_counter
  import turn_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         done
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples its inputs as they were before the edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      // Saturate rather than wrap. A very long idle phase must not make
      // done fall back to 0.
      count <= count + 1'b1;
    end
  end

  assign done = (count >= limit);

endmodule

// File: rtl/turn_manager.sv
// Turn sequencer and keyboard gate placed in front of the two players.
//   clk, reset     : system clock, synchronous active-high reset
//   frame_tick     : one-clk pulse per video frame
//   keycode        : raw keyboard keycode (0 = no key)
//   shoot_key0/1   : Shoot keycode of player 0 / player 1
//   bomb_active    : bit i = player i has a bomb in flight
//   keycode_p0/p1  : registered keycode routed to each player
//   active_id      : player whose turn it is
//   phase          : current turn_state_t encoding
//   turn_time_left : remaining aim frames
//   turn_start     : one-clk pulse on entry to AIM (and once after reset)
module turn_manager
  import turn_pkg::*;
#(
  parameter int unsigned TURN_FRAMES           = 600,
  parameter int unsigned FIRE_WAIT_FRAMES      = 60,
  parameter int unsigned FLIGHT_TIMEOUT_FRAMES = 300,
  parameter int unsigned SWITCH_FRAMES         = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [7:0]       keycode,
  input  logic [7:0]       shoot_key0,
  input  logic [7:0]       shoot_key1,
  input  logic [1:0]       bomb_active,
  output logic [7:0]       keycode_p0,
  output logic [7:0]       keycode_p1,
  output logic             active_id,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] turn_time_left,
  output logic             turn_start
);

  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_FRAMES);
  localparam logic [CNT_W-1:0] FIRE_LIMIT  = CNT_W'(FIRE_WAIT_FRAMES);
  localparam logic [CNT_W-1:0] FLT_LIMIT   = CNT_W'(FLIGHT_TIMEOUT_FRAMES);
  localparam logic [CNT_W-1:0] SWT_LIMIT   = CNT_W'(SWITCH_FRAMES);

  turn_state_t      state, next_state;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_done;
  logic             cnt_clear;
  logic             shot;
  logic             own_bomb;
  logic             enter_aim;
  logic             route_keys;

  frame_counter #(.W(CNT_W)) u_frame_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (frame_tick),
    .limit  (cnt_limit),
    .count  (cnt_value),
    .done   (cnt_done)
  );

  // NOTE: every signal written here gets a default first. A path that left
  // one unassigned would infer a latch.
  always_comb begin
    next_state = state;
    cnt_limit  = '1;
    shot       = shoot_hit(keycode, active_id ? shoot_key1 : shoot_key0);
    own_bomb   = bomb_active[active_id];

    unique case (state)
      AIM: begin
        // A shot on the same edge the timer hits 0 still counts.
        if (shot) begin
          next_state = FIRE_WAIT;
        end else if (turn_time_left == '0) begin
          next_state = SWITCH;
        end
      end
      FIRE_WAIT: begin
        cnt_limit = FIRE_LIMIT;
        if (own_bomb) begin
          next_state = FLIGHT;
        end else if (cnt_done) begin
          next_state = SWITCH;
        end
      end
      FLIGHT: begin
        cnt_limit = FLT_LIMIT;
        if (!own_bomb || cnt_done) begin
          next_state = SWITCH;
        end
      end
      SWITCH: begin
        cnt_limit = SWT_LIMIT;
        if (cnt_done) begin
          next_state = AIM;
        end
      end
      default: next_state = AIM;
    endcase
  end

  // The counter restarts on every state change, so each phase times from 0.
  assign cnt_clear  = (next_state != state);
  assign enter_aim  = (state == SWITCH) && (next_state == AIM);
  assign route_keys = (state == AIM) || (state == FIRE_WAIT);
  assign phase      = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= AIM;
      active_id      <= 1'b0;
      turn_time_left <= TURN_LOAD;
      keycode_p0     <= KEY_NONE;
      keycode_p1     <= KEY_NONE;
      // Held high during reset, so player 0 sees a turn_start for the first
      // clk after reset is released.
      turn_start     <= 1'b1;
    end else begin
      state      <= next_state;
      turn_start <= enter_aim;

      if (enter_aim) begin
        active_id      <= ~active_id;
        turn_time_left <= TURN_LOAD;
      end else if ((state == AIM) && frame_tick && (turn_time_left != '0)) begin
        turn_time_left <= turn_time_left - 1'b1;
      end

      keycode_p0 <= (route_keys && !active_id) ? keycode : KEY_NONE;
      keycode_p1 <= (route_keys &&  active_id) ? keycode : KEY_NONE;
    end
  end

endmodule
